// File: rtl/silife_grid_sync_edge_peer.sv
`default_nettype none
// ============================================================================
// Module      : silife_grid_sync_edge_peer
// Description : Far-end peer of the grid edge sync link. Runs directly in the
//               sync clock domain. Each frame receives WIDTH edge cells plus a
//               corner bit, and returns the local cells and corner in the same
//               frame. Complete frames are committed to parallel outputs.
//               Frames that are too short or too long raise sticky flags.
// Ports       : i_sync_clk    - frame bit clock (posedge)
//               reset         - synchronous, active-high
//               i_sync_active - frame enable from the initiator
//               i_sync_in     - serial data from the neighbour
//               o_sync_out    - serial data to the neighbour (sampled on negedge)
//               i_cells       - local edge cells, captured at frame start
//               i_corner      - local corner, captured at frame start
//               i_err_clear   - clears both sticky error flags
//               o_cells       - cells of the last good frame
//               o_corner      - corner of the last good frame
//               o_frame_valid - one-cycle pulse after a good commit
//               o_busy        - frame in progress (RX or CORNER)
//               o_err_short   - sticky: active dropped before corner bit
//               o_err_long    - sticky: active held past corner bit
//               o_frame_count - good-frame counter, wraps
// Revision    : 1.0 - initial release
// ============================================================================
module silife_grid_sync_edge_peer #(
  parameter int WIDTH = 32
) (
  input  logic             i_sync_clk,
  input  logic             reset,
  input  logic             i_sync_active,
  input  logic             i_sync_in,
  output logic             o_sync_out,
  input  logic [WIDTH-1:0] i_cells,
  input  logic             i_corner,
  input  logic             i_err_clear,
  output logic [WIDTH-1:0] o_cells,
  output logic             o_corner,
  output logic             o_frame_valid,
  output logic             o_busy,
  output logic             o_err_short,
  output logic             o_err_long,
  output logic [7:0]       o_frame_count
);

  localparam int IDX_W = $clog2(WIDTH + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RX     = 2'd1,
    CORNER = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [WIDTH:0]   tx_sr_q, tx_sr_d;
  logic [WIDTH-1:0] rx_sr_q, rx_sr_d;
  logic             sync_out_q, sync_out_d;
  logic [WIDTH-1:0] cells_q, cells_d;
  logic             corner_q, corner_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             err_short_q, err_short_d;
  logic             err_long_q, err_long_d;
  logic [7:0]       count_q, count_d;
  logic             set_short, set_long;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    tx_sr_d    = tx_sr_q;
    rx_sr_d    = rx_sr_q;
    sync_out_d = 1'b0;
    cells_d    = cells_q;
    corner_d   = corner_q;
    valid_d    = 1'b0;
    busy_d     = 1'b0;
    count_d    = count_q;
    set_short  = 1'b0;
    set_long   = 1'b0;

    if (!i_sync_active) begin
      state_d = IDLE;
      idx_d   = '0;
      // Partial frame is dropped; committed outputs are left untouched.
      if (state_q == RX || state_q == CORNER) set_short = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          tx_sr_d    = {i_corner, i_cells};
          sync_out_d = i_cells[0];
          // Shift in at the top so bit 0 lands at index 0 after WIDTH bits.
          rx_sr_d    = WIDTH'({i_sync_in, rx_sr_q} >> 1);
          idx_d      = IDX_W'(1);
          state_d    = (WIDTH == 1) ? CORNER : RX;
          busy_d     = 1'b1;
        end
        RX: begin
          rx_sr_d    = WIDTH'({i_sync_in, rx_sr_q} >> 1);
          // tx_sr[1] holds the bit for the current index; bit 0 went out at start.
          sync_out_d = tx_sr_q[1];
          tx_sr_d    = tx_sr_q >> 1;
          idx_d      = idx_q + 1'b1;
          if (idx_q == LAST_IDX) state_d = CORNER;
          busy_d     = 1'b1;
        end
        CORNER: begin
          cells_d    = rx_sr_q;
          corner_d   = i_sync_in;
          valid_d    = 1'b1;
          count_d    = count_q + 8'd1;
          sync_out_d = tx_sr_q[1];
          state_d    = DONE;
        end
        default: begin
          set_long = 1'b1;
        end
      endcase
    end

    // A new error in the same cycle as a clear request survives the clear.
    err_short_d = set_short | (err_short_q & ~i_err_clear);
    err_long_d  = set_long  | (err_long_q  & ~i_err_clear);
  end

  always_ff @(posedge i_sync_clk) begin
    if (reset) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      tx_sr_q     <= '0;
      rx_sr_q     <= '0;
      sync_out_q  <= 1'b0;
      cells_q     <= '0;
      corner_q    <= 1'b0;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
      err_short_q <= 1'b0;
      err_long_q  <= 1'b0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      tx_sr_q     <= tx_sr_d;
      rx_sr_q     <= rx_sr_d;
      sync_out_q  <= sync_out_d;
      cells_q     <= cells_d;
      corner_q    <= corner_d;
      valid_q     <= valid_d;
      busy_q      <= busy_d;
      err_short_q <= err_short_d;
      err_long_q  <= err_long_d;
      count_q     <= count_d;
    end
  end

  assign o_sync_out    = sync_out_q;
  assign o_cells       = cells_q;
  assign o_corner      = corner_q;
  assign o_frame_valid = valid_q;
  assign o_busy        = busy_q;
  assign o_err_short   = err_short_q;
  assign o_err_long    = err_long_q;
  assign o_frame_count = count_q;

endmodule
`default_nettype wire

// File: tb/tb_silife_grid_sync_edge_peer.sv
`default_nettype none
// ============================================================================
// Module      : tb_silife_grid_sync_edge_peer
// Description : Self-checking bench for silife_grid_sync_edge_peer (WIDTH=4,
//               plus a WIDTH=1 instance for the minimal frame).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_silife_grid_sync_edge_peer;

  logic       clk = 1'b0;
  logic       reset;
  logic       act, din, cor, clr;
  logic [3:0] cells;
  logic       dout, valid, busy, esh, elg, ocor;
  logic [7:0] cnt;
  logic [3:0] ocells;

  logic       act1, din1, cor1;
  logic [0:0] cells1;
  logic       dout1, valid1, busy1, esh1, elg1, ocor1;
  logic [7:0] cnt1;
  logic [0:0] ocells1;

  int tests = 0;
  int fails = 0;
  int pulses = 0;

  always #5 clk = ~clk;

  silife_grid_sync_edge_peer #(.WIDTH(4)) dut (
    .i_sync_clk(clk), .reset(reset), .i_sync_active(act), .i_sync_in(din),
    .o_sync_out(dout), .i_cells(cells), .i_corner(cor), .i_err_clear(clr),
    .o_cells(ocells), .o_corner(ocor), .o_frame_valid(valid), .o_busy(busy),
    .o_err_short(esh), .o_err_long(elg), .o_frame_count(cnt)
  );

  silife_grid_sync_edge_peer #(.WIDTH(1)) dut1 (
    .i_sync_clk(clk), .reset(reset), .i_sync_active(act1), .i_sync_in(din1),
    .o_sync_out(dout1), .i_cells(cells1), .i_corner(cor1), .i_err_clear(clr),
    .o_cells(ocells1), .o_corner(ocor1), .o_frame_valid(valid1), .o_busy(busy1),
    .o_err_short(esh1), .o_err_long(elg1), .o_frame_count(cnt1)
  );

  typedef struct {
    logic        act;
    logic        din;
    logic [3:0]  cells;
    logic        cor;
    logic        clr;
    logic [17:0] exp;  // {out,valid,busy,short,long,count[7:0],cells[3:0],corner}
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic a, input logic d, input logic [3:0] c,
                              input logic co, input logic cl,
                              input logic o, input logic v, input logic b,
                              input logic s, input logic l, input logic [7:0] n,
                              input logic [3:0] oc, input logic ocr);
    vec_t r;
    r.act = a; r.din = d; r.cells = c; r.cor = co; r.clr = cl;
    r.exp = {o, v, b, s, l, n, oc, ocr};
    return r;
  endfunction

  function automatic logic [17:0] outs();
    return {dout, valid, busy, esh, elg, cnt, ocells, ocor};
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (valid) pulses++;
  endtask

  // One full WIDTH=4 frame followed by one idle bit.
  task automatic run_frame(input logic [3:0] c, input logic co, input logic [4:0] rx);
    cells = c; cor = co;
    for (int k = 0; k < 5; k++) begin
      act = 1'b1; din = rx[k];
      tick();
    end
    act = 1'b0; din = 1'b0;
    tick();
  endtask

  initial begin
    reset = 1'b1; act = 0; din = 0; cor = 0; clr = 0; cells = 4'h0;
    act1 = 0; din1 = 0; cor1 = 0; cells1 = 1'b0;

    // Frame 1: cells 1010, corner 1, rx 1,1,0,0 + corner 1
    vecs.push_back(mk(1,1,4'hA,1,0, 0,0,1,0,0,8'd0,4'h0,0));
    vecs.push_back(mk(1,1,4'hA,1,0, 1,0,1,0,0,8'd0,4'h0,0));
    vecs.push_back(mk(1,0,4'hA,1,0, 0,0,1,0,0,8'd0,4'h0,0));
    vecs.push_back(mk(1,0,4'hA,1,0, 1,0,1,0,0,8'd0,4'h0,0));
    vecs.push_back(mk(1,1,4'hA,1,0, 1,1,0,0,0,8'd1,4'h3,1));
    vecs.push_back(mk(0,0,4'hA,1,0, 0,0,0,0,0,8'd1,4'h3,1));
    // Short frame: active drops after bit 2
    vecs.push_back(mk(1,0,4'h5,0,0, 1,0,1,0,0,8'd1,4'h3,1));
    vecs.push_back(mk(1,0,4'h5,0,0, 0,0,1,0,0,8'd1,4'h3,1));
    vecs.push_back(mk(1,0,4'h5,0,0, 1,0,1,0,0,8'd1,4'h3,1));
    vecs.push_back(mk(0,0,4'h5,0,0, 0,0,0,1,0,8'd1,4'h3,1));
    // Recovery frame: cells 0110, corner 0, rx 0,1,0,1 + corner 0
    vecs.push_back(mk(1,0,4'h6,0,0, 0,0,1,1,0,8'd1,4'h3,1));
    vecs.push_back(mk(1,1,4'h6,0,0, 1,0,1,1,0,8'd1,4'h3,1));
    vecs.push_back(mk(1,0,4'h6,0,0, 1,0,1,1,0,8'd1,4'h3,1));
    vecs.push_back(mk(1,1,4'h6,0,0, 0,0,1,1,0,8'd1,4'h3,1));
    vecs.push_back(mk(1,0,4'h6,0,0, 0,1,0,1,0,8'd2,4'hA,0));
    vecs.push_back(mk(0,0,4'h6,0,0, 0,0,0,1,0,8'd2,4'hA,0));
    // Long frame: cells 0001, corner 0, rx 1,0,0,0 + corner 1, then 3 extra bits
    vecs.push_back(mk(1,1,4'h1,0,0, 1,0,1,1,0,8'd2,4'hA,0));
    vecs.push_back(mk(1,0,4'h1,0,0, 0,0,1,1,0,8'd2,4'hA,0));
    vecs.push_back(mk(1,0,4'h1,0,0, 0,0,1,1,0,8'd2,4'hA,0));
    vecs.push_back(mk(1,0,4'h1,0,0, 0,0,1,1,0,8'd2,4'hA,0));
    vecs.push_back(mk(1,1,4'h1,0,0, 0,1,0,1,0,8'd3,4'h1,1));
    vecs.push_back(mk(1,0,4'h1,0,0, 0,0,0,1,1,8'd3,4'h1,1));
    vecs.push_back(mk(1,0,4'h1,0,1, 0,0,0,0,1,8'd3,4'h1,1));  // set beats clear
    vecs.push_back(mk(1,0,4'h1,0,0, 0,0,0,0,1,8'd3,4'h1,1));
    vecs.push_back(mk(0,0,4'h1,0,0, 0,0,0,0,1,8'd3,4'h1,1));
    vecs.push_back(mk(0,0,4'h1,0,1, 0,0,0,0,0,8'd3,4'h1,1));
    // Inputs change mid-frame: cells F->0 and corner 0->1 at bit 2
    vecs.push_back(mk(1,0,4'hF,0,0, 1,0,1,0,0,8'd3,4'h1,1));
    vecs.push_back(mk(1,0,4'hF,0,0, 1,0,1,0,0,8'd3,4'h1,1));
    vecs.push_back(mk(1,0,4'h0,1,0, 1,0,1,0,0,8'd3,4'h1,1));
    vecs.push_back(mk(1,0,4'h0,1,0, 1,0,1,0,0,8'd3,4'h1,1));
    vecs.push_back(mk(1,0,4'h0,1,0, 0,1,0,0,0,8'd4,4'h0,0));
    vecs.push_back(mk(0,0,4'h0,1,0, 0,0,0,0,0,8'd4,4'h0,0));

    tick(); tick();
    chk("reset_state", {14'd0, outs()}, 32'd0);
    chk("reset_state_w1", {dout1, valid1, busy1, esh1, elg1, cnt1, ocells1, ocor1}, 32'd0);
    reset = 1'b0;

    foreach (vecs[i]) begin
      act = vecs[i].act; din = vecs[i].din; cells = vecs[i].cells;
      cor = vecs[i].cor; clr = vecs[i].clr;
      tick();
      chk($sformatf("vec%0d", i), {14'd0, outs()}, {14'd0, vecs[i].exp});
    end
    clr = 1'b0;

    // Reset asserted at bit 2 of a frame
    cells = 4'hF; cor = 1'b1; act = 1'b1; din = 1'b1;
    tick(); tick();
    reset = 1'b1;
    tick();
    chk("midframe_reset", {14'd0, outs()}, 32'd0);
    reset = 1'b0; act = 1'b0;
    tick();
    chk("post_reset_no_err", {30'd0, esh, elg}, 32'd0);
    run_frame(4'hA, 1'b1, 5'b10011);
    chk("post_reset_frame", {14'd0, outs()}, {14'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1, 4'h3, 1'b1});

    // WIDTH=1: bit 0 is the single cell, bit 1 the corner
    cells1 = 1'b1; cor1 = 1'b1; act1 = 1'b1; din1 = 1'b1;
    tick();
    chk("w1_bit0", {29'd0, dout1, busy1, valid1}, {29'd0, 1'b1, 1'b1, 1'b0});
    din1 = 1'b0;
    tick();
    chk("w1_commit", {24'd0, dout1, valid1, busy1, ocells1, ocor1, esh1, elg1, cnt1 == 8'd1},
        {24'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1});
    act1 = 1'b0;
    tick();
    chk("w1_idle", {29'd0, dout1, valid1, esh1}, 32'd0);

    // 256 back-to-back frames wrap the counter back to 0
    reset = 1'b1;
    tick();
    reset = 1'b0;
    pulses = 0;
    for (int f = 1; f <= 256; f++) begin
      run_frame(4'hF, 1'b1, 5'b11111);
      if (f == 255) chk("count_255", {24'd0, cnt}, 32'd255);
    end
    chk("count_wrap", {24'd0, cnt}, 32'd0);
    chk("valid_pulses", pulses, 256);
    chk("wrap_cells", {27'd0, ocells, ocor}, {27'd0, 4'hF, 1'b1});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
